// File: rtl/prach_hb_tdm.sv
// Half-band decimate-by-2 filter, time-multiplexed over NCH channels with per-channel
// I/Q history, four-stage pipeline, round-half-up, saturation and per-pair bypass.
module prach_hb_tdm #(
   parameter int DW    = 16,
   parameter int CW    = 18,
   parameter int NCH   = 8,
   parameter int NHALF = 2,
   parameter int COEF [NHALF] = '{-4096, 36864}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic signed [DW-1:0] din_dp1 [2],
   input  logic signed [DW-1:0] din_dp2 [2],
   input  logic                 din_dv,
   input  logic [7:0]           din_chn,
   input  logic                 sync_in,
   input  logic                 bypass,
   output logic [2*DW-1:0]      dout_dq,
   output logic                 dout_dv,
   output logic [7:0]           dout_chn,
   output logic                 sync_out,
   output logic                 ovf
);

   localparam int NE  = 2 * NHALF;
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW  = DW + CW + 1;
   localparam int AW  = PW + $clog2(NHALF + 1) + 1;
   localparam logic [8:0]           NCH_L   = 9'(NCH);
   localparam logic signed [AW-1:0] RND     = AW'(1) <<< (CW - 2);
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   logic signed [DW-1:0] even_q [NCH][2][NE];
   logic signed [DW-1:0] even_d [NCH][2][NE];
   logic signed [DW-1:0] odd_q  [NCH][2][NHALF];
   logic signed [DW-1:0] odd_d  [NCH][2][NHALF];
   logic                 accept;
   logic [CHW-1:0]       chn_idx;
   logic signed [DW-1:0] win_e [2][NE];
   logic signed [DW-1:0] win_o [2][NHALF];

   logic [3:1]           vld_q, vld_d, sync_q, sync_d, byp_q, byp_d;
   logic [7:0]           chn_q [3:1];
   logic [7:0]           chn_d [3:1];
   logic signed [DW-1:0] bp_q  [3:1][2];
   logic signed [DW-1:0] bp_d  [3:1][2];

   logic signed [DW-1:0] s1_e_q [2][NE];
   logic signed [DW-1:0] s1_e_d [2][NE];
   logic signed [DW-1:0] s1_o_q [2];
   logic signed [DW-1:0] s1_o_d [2];
   logic signed [PW-1:0] s2_prod_q [2][NHALF];
   logic signed [PW-1:0] s2_prod_d [2][NHALF];
   logic signed [PW-1:0] s2_odd_q [2];
   logic signed [PW-1:0] s2_odd_d [2];
   logic signed [AW-1:0] s3_acc_q [2];
   logic signed [AW-1:0] s3_acc_d [2];

   logic signed [AW-1:0] rnd [2];
   logic signed [AW-1:0] shr [2];
   logic signed [DW-1:0] lane_val [2];
   logic [1:0]           lane_sat;

   logic [2*DW-1:0]      dout_dq_q, dout_dq_d;
   logic                 dout_dv_q, dout_dv_d;
   logic [7:0]           dout_chn_q, dout_chn_d;
   logic                 sync_out_q, sync_out_d;
   logic                 ovf_q, ovf_d;

   // History is written on the accepting edge, so a back-to-back pair on the same
   // channel already reads the updated window; sync clears before the insert.
   always_comb begin
      accept  = din_dv && ({1'b0, din_chn} < NCH_L);
      chn_idx = din_chn[CHW-1:0];
      even_d  = even_q;
      odd_d   = odd_q;
      for (int l = 0; l < 2; l++) begin
         win_e[l][0] = din_dp1[l];
         win_o[l][0] = din_dp2[l];
         for (int k = 1; k < NE; k++)
            win_e[l][k] = sync_in ? '0 : even_q[chn_idx][l][k-1];
         for (int k = 1; k < NHALF; k++)
            win_o[l][k] = sync_in ? '0 : odd_q[chn_idx][l][k-1];
         if (accept) begin
            for (int k = 0; k < NE; k++)
               even_d[chn_idx][l][k] = win_e[l][k];
            for (int k = 0; k < NHALF; k++)
               odd_d[chn_idx][l][k] = win_o[l][k];
         end
      end
   end

   always_comb begin
      vld_d    = {vld_q[2:1], accept};
      sync_d   = {sync_q[2:1], sync_in & accept};
      byp_d    = {byp_q[2:1], bypass};
      chn_d[1] = din_chn;
      chn_d[2] = chn_q[1];
      chn_d[3] = chn_q[2];
      for (int l = 0; l < 2; l++) begin
         bp_d[1][l] = din_dp2[l];
         bp_d[2][l] = bp_q[1][l];
         bp_d[3][l] = bp_q[2][l];
      end
   end

   // Symmetric pre-add and multiply, then a full-precision sum with the centre tap.
   always_comb begin
      s1_e_d = win_e;
      for (int l = 0; l < 2; l++) begin
         s1_o_d[l] = win_o[l][NHALF-1];
         for (int k = 0; k < NHALF; k++)
            s2_prod_d[l][k] = PW'(CW'(COEF[k])) *
                              (PW'(s1_e_q[l][k]) + PW'(s1_e_q[l][NE-1-k]));
         s2_odd_d[l] = PW'(s1_o_q[l]) <<< (CW - 2);
         s3_acc_d[l] = AW'(s2_odd_q[l]);
         for (int k = 0; k < NHALF; k++)
            s3_acc_d[l] = s3_acc_d[l] + AW'(s2_prod_q[l][k]);
      end
   end

   always_comb begin
      dout_dv_d  = vld_q[3];
      dout_dq_d  = dout_dq_q;
      dout_chn_d = dout_chn_q;
      sync_out_d = 1'b0;
      ovf_d      = 1'b0;
      lane_sat   = '0;
      for (int l = 0; l < 2; l++) begin
         rnd[l] = s3_acc_q[l] + RND;
         shr[l] = rnd[l] >>> (CW - 1);
         lane_val[l] = shr[l][DW-1:0];
         if (shr[l] > SAT_MAX) begin
            lane_val[l] = SAT_MAX[DW-1:0];
            lane_sat[l] = 1'b1;
         end else if (shr[l] < SAT_MIN) begin
            lane_val[l] = SAT_MIN[DW-1:0];
            lane_sat[l] = 1'b1;
         end
      end
      if (vld_q[3]) begin
         dout_chn_d = chn_q[3];
         sync_out_d = sync_q[3];
         if (byp_q[3]) begin
            dout_dq_d = {bp_q[3][1], bp_q[3][0]};
         end else begin
            dout_dq_d = {lane_val[1], lane_val[0]};
            ovf_d     = |lane_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++)
            for (int l = 0; l < 2; l++) begin
               for (int k = 0; k < NE; k++)
                  even_q[c][l][k] <= '0;
               for (int k = 0; k < NHALF; k++)
                  odd_q[c][l][k] <= '0;
            end
      end else begin
         even_q <= even_d;
         odd_q  <= odd_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         sync_q <= '0;
         byp_q  <= '0;
         for (int s = 1; s <= 3; s++) begin
            chn_q[s]    <= '0;
            bp_q[s][0]  <= '0;
            bp_q[s][1]  <= '0;
         end
         for (int l = 0; l < 2; l++) begin
            s1_o_q[l]   <= '0;
            s2_odd_q[l] <= '0;
            s3_acc_q[l] <= '0;
            for (int k = 0; k < NE; k++)
               s1_e_q[l][k] <= '0;
            for (int k = 0; k < NHALF; k++)
               s2_prod_q[l][k] <= '0;
         end
         dout_dq_q  <= '0;
         dout_dv_q  <= 1'b0;
         dout_chn_q <= '0;
         sync_out_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         vld_q      <= vld_d;
         sync_q     <= sync_d;
         byp_q      <= byp_d;
         chn_q      <= chn_d;
         bp_q       <= bp_d;
         s1_e_q     <= s1_e_d;
         s1_o_q     <= s1_o_d;
         s2_prod_q  <= s2_prod_d;
         s2_odd_q   <= s2_odd_d;
         s3_acc_q   <= s3_acc_d;
         dout_dq_q  <= dout_dq_d;
         dout_dv_q  <= dout_dv_d;
         dout_chn_q <= dout_chn_d;
         sync_out_q <= sync_out_d;
         ovf_q      <= ovf_d;
      end
   end

   assign dout_dq  = dout_dq_q;
   assign dout_dv  = dout_dv_q;
   assign dout_chn = dout_chn_q;
   assign sync_out = sync_out_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_prach_hb_tdm.sv
// Directed bench for prach_hb_tdm: hand-computed expectations travel through a
// four-slot delay line and are compared against the outputs every cycle.
module tb_prach_hb_tdm;

   localparam int DW = 16;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b1;
   logic signed [DW-1:0] din_dp1 [2];
   logic signed [DW-1:0] din_dp2 [2];
   logic                 din_dv  = 1'b0;
   logic [7:0]           din_chn = 8'd0;
   logic                 sync_in = 1'b0;
   logic                 bypass  = 1'b0;
   logic [2*DW-1:0]      dout_dq;
   logic                 dout_dv;
   logic [7:0]           dout_chn;
   logic                 sync_out;
   logic                 ovf;

   typedef struct {
      logic        vld;
      logic [7:0]  chn;
      logic        sync;
      logic [15:0] i;
      logic [15:0] q;
      logic        ovf;
      int          id;
   } exp_t;

   int          compared   = 0;
   int          mismatched = 0;
   int          stepId     = 0;
   exp_t        pipe [4];
   exp_t        cur;
   logic [31:0] lastDq;

   always #5 clk = ~clk;

   prach_hb_tdm #(.DW(DW), .CW(18), .NCH(8), .NHALF(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_dp1  (din_dp1),
      .din_dp2  (din_dp2),
      .din_dv   (din_dv),
      .din_chn  (din_chn),
      .sync_in  (sync_in),
      .bypass   (bypass),
      .dout_dq  (dout_dq),
      .dout_dv  (dout_dv),
      .dout_chn (dout_chn),
      .sync_out (sync_out),
      .ovf      (ovf)
   );

   function automatic exp_t idleExp();
      exp_t e;
      e.vld  = 1'b0;
      e.chn  = 8'd0;
      e.sync = 1'b0;
      e.i    = 16'd0;
      e.q    = 16'd0;
      e.ovf  = 1'b0;
      e.id   = -1;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock: shift the expectation line and check whatever is due this cycle.
   task automatic tick();
      exp_t  due;
      string tag;
      @(posedge clk);
      #1;
      for (int s = 3; s > 0; s--) pipe[s] = pipe[s-1];
      pipe[0] = cur;
      cur     = idleExp();
      due     = pipe[3];
      tag     = (due.id < 0) ? "idle" : $sformatf("v%0d", due.id);
      checkOutput({tag, ".dv"}, 32'(dout_dv), 32'(due.vld));
      if (due.vld) begin
         checkOutput({tag, ".dq"}, dout_dq, {due.q, due.i});
         checkOutput({tag, ".chn"}, 32'(dout_chn), 32'(due.chn));
         checkOutput({tag, ".sync"}, 32'(sync_out), 32'(due.sync));
         checkOutput({tag, ".ovf"}, 32'(ovf), 32'(due.ovf));
         lastDq = {due.q, due.i};
      end else begin
         checkOutput({tag, ".hold"}, dout_dq, lastDq);
         checkOutput({tag, ".ovf0"}, 32'(ovf), 32'd0);
         checkOutput({tag, ".sync0"}, 32'(sync_out), 32'd0);
      end
   endtask

   task automatic applyStimulus(input int chn, input int p1i, input int p1q,
                                input int p2i, input int p2q,
                                input bit sync, input bit byp, input bit expVld,
                                input int expI, input int expQ, input bit expOvf);
      din_dv     = 1'b1;
      din_chn    = 8'(chn);
      din_dp1[0] = 16'(p1i);
      din_dp1[1] = 16'(p1q);
      din_dp2[0] = 16'(p2i);
      din_dp2[1] = 16'(p2q);
      sync_in    = sync;
      bypass     = byp;
      cur.vld    = expVld;
      cur.chn    = 8'(chn);
      cur.sync   = sync & expVld;
      cur.i      = 16'(expI);
      cur.q      = 16'(expQ);
      cur.ovf    = expOvf;
      cur.id     = stepId;
      stepId++;
      tick();
      din_dv  = 1'b0;
      sync_in = 1'b0;
      bypass  = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      din_dv  = 1'b0;
      sync_in = 1'b0;
      bypass  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic doReset();
      din_dv     = 1'b0;
      sync_in    = 1'b0;
      bypass     = 1'b0;
      din_chn    = 8'd0;
      din_dp1[0] = '0;
      din_dp1[1] = '0;
      din_dp2[0] = '0;
      din_dp2[1] = '0;
      rst_n      = 1'b0;
      #1;
      checkOutput("rst.dq", dout_dq, 32'd0);
      checkOutput("rst.dv", 32'(dout_dv), 32'd0);
      checkOutput("rst.chn", 32'(dout_chn), 32'd0);
      checkOutput("rst.sync", 32'(sync_out), 32'd0);
      checkOutput("rst.ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rst.dv2", 32'(dout_dv), 32'd0);
      checkOutput("rst.dq2", dout_dq, 32'd0);
      rst_n = 1'b1;
      for (int s = 0; s < 4; s++) pipe[s] = idleExp();
      cur    = idleExp();
      lastDq = '0;
   endtask

   initial begin
      #2;
      doReset();
      idleCycles(2);

      $display("[TB] odd impulse on channel 0");
      applyStimulus(0, 0, 0, 1000, 1000, 1, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 500, 500, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idleCycles(4);

      $display("[TB] even impulse on channel 3");
      applyStimulus(3, 16384, -16384, 0, 0, 1, 0, 1, -512, 512, 0);
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 1, 4608, -4608, 0);
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 1, 4608, -4608, 0);
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 1, -512, 512, 0);
      applyStimulus(3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idleCycles(4);

      $display("[TB] DC on channel 1");
      applyStimulus(1, 32767, 32767, 32767, 32767, 1, 0, 1, -1024, -1024, 0);
      applyStimulus(1, 32767, 32767, 32767, 32767, 0, 0, 1, 24575, 24575, 0);
      applyStimulus(1, 32767, 32767, 32767, 32767, 0, 0, 1, 32767, 32767, 1);
      applyStimulus(1, 32767, 32767, 32767, 32767, 0, 0, 1, 32767, 32767, 0);
      applyStimulus(1, 32767, 32767, 32767, 32767, 0, 0, 1, 32767, 32767, 0);
      applyStimulus(1, -32768, -32768, -32768, -32768, 1, 0, 1, 1024, 1024, 0);
      applyStimulus(1, -32768, -32768, -32768, -32768, 0, 0, 1, -24576, -24576, 0);
      applyStimulus(1, -32768, -32768, -32768, -32768, 0, 0, 1, -32768, -32768, 1);
      applyStimulus(1, -32768, -32768, -32768, -32768, 0, 0, 1, -32768, -32768, 0);
      applyStimulus(1, -32768, -32768, -32768, -32768, 0, 0, 1, -32768, -32768, 0);
      idleCycles(4);

      $display("[TB] saturation on channel 4");
      applyStimulus(4, -32768, -32768, 0, 0, 1, 0, 1, 1024, 1024, 0);
      applyStimulus(4, 32767, 32767, 0, 0, 0, 0, 1, -10240, -10240, 0);
      applyStimulus(4, 32767, 32767, 32767, 32767, 0, 0, 1, -1024, -1024, 0);
      applyStimulus(4, -32768, -32768, 0, 0, 0, 0, 1, 32767, 32767, 1);
      applyStimulus(4, 0, 0, 0, 0, 0, 0, 1, -1024, -1024, 0);
      idleCycles(4);

      $display("[TB] TDM interleave with out-of-range channel 9");
      for (int c = 0; c < 8; c++) begin
         applyStimulus(c, 0, 0, 1000 * (c + 1), -1000 * (c + 1), 1, 0, 1, 0, 0, 0);
         if (c == 3) applyStimulus(9, 12345, -1, 30000, 30000, 1, 0, 0, 0, 0, 0);
      end
      for (int c = 0; c < 8; c++) begin
         applyStimulus(c, 0, 0, 0, 0, 0, 0, 1, 500 * (c + 1), -500 * (c + 1), 0);
         if (c == 5) applyStimulus(9, 20000, 20000, -30000, 30000, 1, 0, 0, 0, 0, 0);
      end
      for (int c = 0; c < 8; c++)
         applyStimulus(c, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idleCycles(4);

      $display("[TB] bypass toggling on channel 2");
      applyStimulus(2, 5, 5, -7, -7, 1, 1, 1, -7, -7, 0);
      applyStimulus(2, 0, 0, 0, 0, 0, 0, 1, -2, -2, 0);
      applyStimulus(2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      applyStimulus(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(2, 100, 100, -32768, 32767, 0, 1, 1, -32768, 32767, 0);
      idleCycles(5);

      $display("[TB] reset with pairs in flight");
      applyStimulus(5, 1000, 1000, 2000, 2000, 1, 0, 1, 0, 0, 0);
      applyStimulus(5, 3000, 3000, 4000, 4000, 0, 0, 1, 0, 0, 0);
      applyStimulus(5, 5000, 5000, 6000, 6000, 0, 0, 1, 0, 0, 0);
      doReset();
      applyStimulus(0, 0, 0, 1000, 1000, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 500, 500, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idleCycles(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
